// File: rtl/memory_access_controller.sv
// Load/store unit bridging a core request port to a single-beat word memory.
// Handles RISC-V sub-word alignment, strobe/lane generation, load extraction and read timeout.
module memory_access_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_fault
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_R = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [1:0]  FAULT_OK        = 2'b00;
    localparam logic [1:0]  FAULT_MISALIGN  = 2'b01;
    localparam logic [1:0]  FAULT_ILLEGAL   = 2'b10;
    localparam logic [1:0]  FAULT_TIMEOUT   = 2'b11;
    localparam logic [15:0] CNT_LIMIT       = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_we;
    logic [2:0]  r_type;
    logic [1:0]  r_offset;
    logic        r_mem_valid;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_wstrb;
    logic [31:0] r_mem_wdata;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic [1:0]  r_rsp_fault;

    logic        w_legal;
    logic        w_misaligned;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    // Request decode. Type bits [1:0] give the size (B/H/W), bit 2 marks unsigned loads.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_wstrb = 4'b0000;
        w_wdata = 32'h0;
        w_legal = (req_type[1:0] != 2'b11) && !(req_type[2] && (req_we || req_type[1]));
        w_misaligned = ((req_type[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_type[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        if (req_we) begin
            case (req_type[1:0])
                2'b00: begin
                    w_wstrb = 4'b0001 << req_addr[1:0];
                    w_wdata = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    w_wstrb = 4'b0011 << req_addr[1:0];
                    w_wdata = {2{req_wdata[15:0]}};
                end
                default: begin
                    w_wstrb = 4'b1111;
                    w_wdata = req_wdata;
                end
            endcase
        end
    end

    // Load extraction from the returned word, using the registered offset and type.
    always_comb begin
        w_byte = mem_rdata[{r_offset, 3'b000} +: 8];
        w_half = r_offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_type[1:0])
            2'b00:   w_load = {{24{w_byte[7] & ~r_type[2]}}, w_byte};
            2'b01:   w_load = {{16{w_half[15] & ~r_type[2]}}, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= 16'd0;
            r_we        <= 1'b0;
            r_type      <= 3'b000;
            r_offset    <= 2'b00;
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wstrb <= 4'b0000;
            r_mem_wdata <= 32'h0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'h0;
            r_rsp_fault <= FAULT_OK;
        end else begin
            // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_type   <= req_type;
                        r_offset <= req_addr[1:0];
                        if (!w_legal) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= 32'h0;
                            r_rsp_fault <= FAULT_ILLEGAL;
                        end else if (w_misaligned) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= 32'h0;
                            r_rsp_fault <= FAULT_MISALIGN;
                        end else begin
                            r_state     <= ISSUE;
                            r_mem_valid <= 1'b1;
                            r_mem_we    <= req_we;
                            r_mem_addr  <= {req_addr[31:2], 2'b00};
                            r_mem_wstrb <= w_wstrb;
                            r_mem_wdata <= w_wdata;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        r_mem_valid <= 1'b0;
                        if (r_we) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= 32'h0;
                            r_rsp_fault <= FAULT_OK;
                        end else begin
                            r_state <= WAIT_R;
                            r_cnt   <= 16'd0;
                        end
                    end
                end
                WAIT_R: begin
                    // Returned data takes priority over a timeout in the same cycle.
                    if (mem_rvalid) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_load;
                        r_rsp_fault <= FAULT_OK;
                    end else if (r_cnt == CNT_LIMIT) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= 32'h0;
                        r_rsp_fault <= FAULT_TIMEOUT;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_data  <= 32'h0;
                        r_rsp_fault <= FAULT_OK;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE);
    assign mem_valid = r_mem_valid;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wstrb = r_mem_wstrb;
    assign mem_wdata = r_mem_wdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_fault = r_rsp_fault;

endmodule

// File: tb/tb_memory_access_controller.sv
// Directed and randomized transactions for memory_access_controller, checked against a
// byte-level reference model of the load/store rules.
module tb_memory_access_controller;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_fault;

    int n_cmp = 0;
    int n_err = 0;

    memory_access_controller #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_type   (req_type),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_fault  (rsp_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference model: access size in bytes and legality from the type code.
    function automatic int size_of(input logic [2:0] t);
        case (t)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic bit legal_of(input logic we, input logic [2:0] t);
        if (we) return (t inside {3'd0, 3'd1, 3'd2});
        return (t inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    endfunction

    task automatic chk_outputs_cleared(input string tag);
        chk({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
        chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
        chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
        chk({tag, "_mem_addr"},  mem_addr,       32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata,      32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"},  rsp_data,       32'd0);
        chk({tag, "_rsp_fault"}, 32'(rsp_fault), 32'd0);
    endtask

    // One complete transaction; called at a negedge with the DUT idle, returns at a negedge.
    task automatic run_txn(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input int rdy_dly,
                           input int rv_dly, input int rsp_dly, input bit no_rv);
        int          size;
        int          off;
        logic [1:0]  e_fault;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic [31:0] e_data;
        logic [31:0] mask;
        bit          cmd;

        size    = size_of(typ);
        off     = int'(addr % 4);
        e_strb  = 4'b0000;
        e_wdata = 32'h0;
        e_data  = 32'h0;
        if (!legal_of(we, typ))             e_fault = 2'b10;
        else if ((addr % size) != 0)        e_fault = 2'b01;
        else                                e_fault = 2'b00;
        cmd = (e_fault == 2'b00);
        if (cmd && we) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= off && i < off + size) e_strb[i] = 1'b1;
                e_wdata[8*i +: 8] = wd[8*(i % size) +: 8];
            end
        end
        if (cmd && !we) begin
            if (no_rv) begin
                e_fault = 2'b11;
            end else begin
                e_data = rd >> (8 * off);
                if (size < 4) begin
                    mask   = (32'd1 << (8 * size)) - 32'd1;
                    e_data = e_data & mask;
                    if (typ < 3'd4 && e_data[8*size-1]) e_data = e_data | ~mask;
                end
            end
        end

        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_type  = typ;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        req_type  = $urandom_range(0, 7);
        req_addr  = $urandom;
        req_wdata = $urandom;

        if (cmd) begin
            for (int k = 0; k <= rdy_dly; k++) begin
                chk("mem_valid", 32'(mem_valid), 32'd1);
                chk("mem_addr",  mem_addr,       addr & 32'hFFFF_FFFC);
                chk("mem_we",    32'(mem_we),    32'(we));
                chk("mem_wstrb", 32'(mem_wstrb), 32'(e_strb));
                chk("mem_wdata", mem_wdata,      e_wdata);
                chk("req_ready_busy", 32'(req_ready), 32'd0);
                mem_ready  = (k == rdy_dly);
                mem_rvalid = (k < rdy_dly);
                mem_rdata  = $urandom;
                @(negedge clk);
            end
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            if (!we) begin
                if (no_rv) begin
                    for (int k = 0; k < TO; k++) begin
                        chk("wait_rsp_valid", 32'(rsp_valid), 32'd0);
                        chk("wait_mem_valid", 32'(mem_valid), 32'd0);
                        @(negedge clk);
                    end
                end else begin
                    for (int k = 0; k <= rv_dly; k++) begin
                        chk("wait_rsp_valid", 32'(rsp_valid), 32'd0);
                        chk("wait_mem_valid", 32'(mem_valid), 32'd0);
                        mem_rvalid = (k == rv_dly);
                        mem_rdata  = (k == rv_dly) ? rd : ~rd;
                        @(negedge clk);
                    end
                    mem_rvalid = 1'b0;
                end
            end
        end

        for (int k = 0; k <= rsp_dly; k++) begin
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_data",  rsp_data,       e_data);
            chk("rsp_fault", 32'(rsp_fault), 32'(e_fault));
            chk("rsp_req_ready", 32'(req_ready), 32'd0);
            chk("rsp_mem_valid", 32'(mem_valid), 32'd0);
            rsp_ready  = (k == rsp_dly);
            mem_rvalid = (k != rsp_dly);
            mem_rdata  = $urandom;
            @(negedge clk);
        end
        rsp_ready  = 1'b0;
        mem_rvalid = 1'b0;
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_req_ready", 32'(req_ready), 32'd1);

        if (no_rv) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rd;
            @(negedge clk);
            mem_rvalid = 1'b0;
            chk("late_rv_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("late_rv_mem_valid", 32'(mem_valid), 32'd0);
            chk("late_rv_req_ready", 32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_type   = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        rsp_ready  = 1'b0;

        repeat (2) @(negedge clk);
        chk_outputs_cleared("reset");
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);

        // LB at 0x103 with zero-wait memory: response three cycles after accept.
        run_txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 0, 0, 0, 1'b0);
        // LHU at 0x202, then misaligned LH at 0x201.
        run_txn(1'b0, 3'b101, 32'h0000_0202, 32'h0, 32'h9234_5678, 0, 0, 0, 1'b0);
        run_txn(1'b0, 3'b001, 32'h0000_0201, 32'h0, 32'h0, 0, 0, 0, 1'b0);
        // SB at 0x3 with memory stalling three cycles.
        run_txn(1'b1, 3'b000, 32'h0000_0003, 32'h0000_00A5, 32'h0, 3, 0, 0, 1'b0);
        // SH upper half, SW, LW, misaligned SW.
        run_txn(1'b1, 3'b001, 32'h0000_0012, 32'h1234_BEEF, 32'h0, 1, 0, 0, 1'b0);
        run_txn(1'b1, 3'b010, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0, 0, 0, 0, 1'b0);
        run_txn(1'b0, 3'b010, 32'h0000_0024, 32'h0, 32'hCAFE_F00D, 2, 1, 0, 1'b0);
        run_txn(1'b1, 3'b010, 32'h0000_0022, 32'h1111_2222, 32'h0, 0, 0, 0, 1'b0);
        // Timeout, then a normal load afterwards.
        run_txn(1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h5555_AAAA, 0, 0, 0, 1'b1);
        run_txn(1'b0, 3'b100, 32'h0000_0041, 32'h0, 32'h0000_F700, 0, 0, 0, 1'b0);
        // Data arriving on the last WAIT_R cycle wins over the timeout.
        run_txn(1'b0, 3'b001, 32'h0000_0046, 32'h0, 32'h8001_0000, 0, TO - 1, 0, 1'b0);
        // Response back-pressure for five cycles.
        run_txn(1'b0, 3'b000, 32'h0000_0050, 32'h0, 32'h0000_007F, 0, 0, 5, 1'b0);
        // Illegal types.
        run_txn(1'b0, 3'b011, 32'h0000_0060, 32'h0, 32'h0, 0, 0, 0, 1'b0);
        run_txn(1'b1, 3'b100, 32'h0000_0060, 32'h0, 32'h0, 0, 0, 0, 1'b0);
        run_txn(1'b0, 3'b111, 32'h0000_0061, 32'h0, 32'h0, 0, 0, 0, 1'b0);

        // Reset pulsed while waiting for read data abandons the transaction.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_type  = 3'b010;
        req_addr  = 32'h0000_0080;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_mid_mem_valid", 32'(mem_valid), 32'd1);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk_outputs_cleared("rst_mid");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("rst_late_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_late_req_ready", 32'(req_ready), 32'd1);
        run_txn(1'b0, 3'b010, 32'h0000_0084, 32'h0, 32'h0BAD_CAFE, 0, 0, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                    $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, TO - 1)),
                    int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
